// File: rtl/acc_bank_if.sv
// rtl/acc_bank_if.sv - op/operand/status bundle between the datapath and acc_bank
interface acc_bank_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_ACC = 4
);
    localparam int SEL_W = $clog2(NUM_ACC);

    logic              op_valid;
    logic [2:0]        op;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] acc_out;
    logic              flag_z;
    logic              flag_c;
    logic              flag_v;
    logic              stack_full;
    logic              stack_empty;
    logic              err;

    modport master (
        output op_valid, op, sel, data_in,
        input  acc_out, flag_z, flag_c, flag_v, stack_full, stack_empty, err
    );

    modport slave (
        input  op_valid, op, sel, data_in,
        output acc_out, flag_z, flag_c, flag_v, stack_full, stack_empty, err
    );
endinterface

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - NUM_ACC accumulators with registered Z/C/V flags and a LIFO context stack
// Define ACC_BANK_SATURATE_EN to make ADD/SUB clamp on signed overflow instead of wrapping.
module acc_bank #(
    parameter int DATA_W      = 16,
    parameter int NUM_ACC     = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic      clk_50m,
    input  logic      reset,
    acc_bank_if.slave bus
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b110;

    logic [DATA_W-1:0] r_acc   [NUM_ACC];
    logic [DATA_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_flag_v;
    logic              r_err;

    logic [DATA_W-1:0] w_cur;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_v_add;
    logic              w_v_sub;
    logic [DATA_W-1:0] w_res_add;
    logic [DATA_W-1:0] w_res_sub;
    logic              w_full;
    logic              w_empty;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_popped;
    logic              w_push_ok;

    assign w_cur   = r_acc[bus.sel];
    // The extra top bit carries out on ADD and reads as borrow on SUB
    assign w_sum   = {1'b0, w_cur} + {1'b0, bus.data_in};
    assign w_diff  = {1'b0, w_cur} - {1'b0, bus.data_in};
    assign w_v_add = (w_cur[DATA_W-1] == bus.data_in[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != w_cur[DATA_W-1]);
    assign w_v_sub = (w_cur[DATA_W-1] != bus.data_in[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != w_cur[DATA_W-1]);

`ifdef ACC_BANK_SATURATE_EN
    // Overflow can only run away from the sign of the current accumulator
    logic [DATA_W-1:0] w_sat;
    assign w_sat     = w_cur[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
    assign w_res_add = w_v_add ? w_sat : w_sum[DATA_W-1:0];
    assign w_res_sub = w_v_sub ? w_sat : w_diff[DATA_W-1:0];
`else
    assign w_res_add = w_sum[DATA_W-1:0];
    assign w_res_sub = w_diff[DATA_W-1:0];
`endif

    assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_wr_idx  = r_sp[IDX_W-1:0];
    assign w_rd_idx  = r_sp[IDX_W-1:0] - IDX_W'(1);
    assign w_popped  = r_stack[w_rd_idx];
    assign w_push_ok = bus.op_valid && (bus.op == OP_PUSH) && !w_full;

    always_ff @(posedge clk_50m) begin
        if (!reset && w_push_ok) begin
            r_stack[w_wr_idx] <= w_cur;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= '0;
            end
            r_sp     <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.op_valid) begin
                case (bus.op)
                    OP_NOP: ;
                    OP_LOAD: begin
                        r_acc[bus.sel] <= bus.data_in;
                        r_flag_z       <= (bus.data_in == '0);
                        r_flag_c       <= 1'b0;
                        r_flag_v       <= 1'b0;
                    end
                    OP_ADD: begin
                        r_acc[bus.sel] <= w_res_add;
                        r_flag_z       <= (w_res_add == '0);
                        r_flag_c       <= w_sum[DATA_W];
                        r_flag_v       <= w_v_add;
                    end
                    OP_SUB: begin
                        r_acc[bus.sel] <= w_res_sub;
                        r_flag_z       <= (w_res_sub == '0);
                        r_flag_c       <= w_diff[DATA_W];
                        r_flag_v       <= w_v_sub;
                    end
                    OP_CLR: begin
                        r_acc[bus.sel] <= '0;
                        r_flag_z       <= 1'b1;
                        r_flag_c       <= 1'b0;
                        r_flag_v       <= 1'b0;
                    end
                    OP_PUSH: begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sp <= r_sp + SP_W'(1);
                        end
                    end
                    OP_POP: begin
                        if (w_empty) begin
                            r_err <= 1'b1;
                        end else begin
                            r_acc[bus.sel] <= w_popped;
                            r_sp           <= r_sp - SP_W'(1);
                            r_flag_z       <= (w_popped == '0);
                            r_flag_c       <= 1'b0;
                            r_flag_v       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.acc_out     = r_acc[bus.sel];
    assign bus.flag_z      = r_flag_z;
    assign bus.flag_c      = r_flag_c;
    assign bus.flag_v      = r_flag_v;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_acc_bank.sv
// tb/tb_acc_bank.sv - self-checking bench for acc_bank: vector table, stack/reset sequences, random vs model
module tb_acc_bank;
    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    acc_bank_if #(.DATA_W(16), .NUM_ACC(4)) bus ();

    acc_bank #(.DATA_W(16), .NUM_ACC(4), .STACK_DEPTH(8)) dut (
        .clk_50m (clk),
        .reset   (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned m_acc [4];
    int unsigned m_stack [$];
    bit m_z, m_c, m_v, m_err;

    typedef struct {
        bit        v;
        bit [2:0]  op;
        bit [1:0]  sel;
        bit [15:0] d;
        bit [15:0] acc;
        bit        z, c, ov, full, empty, err;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int sx(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic void model_reset();
        foreach (m_acc[i]) m_acc[i] = 0;
        m_stack.delete();
        m_z = 0; m_c = 0; m_v = 0; m_err = 0;
    endfunction

    function automatic void model_op(input bit v, input int op, input int sel, input int unsigned d);
        int unsigned a;
        int unsigned r;
        int          s;
        a = m_acc[sel];
        m_err = 0;
        if (!v) return;
        case (op)
            1: begin m_acc[sel] = d; m_z = (d == 0); m_c = 0; m_v = 0; end
            2: begin
                s = sx(a) + sx(d);
                r = (a + d) % 65536;
                m_c = (a + d) > 65535;
                m_v = (s > 32767) || (s < -32768);
`ifdef ACC_BANK_SATURATE_EN
                if (m_v) r = (s > 0) ? 32'h7FFF : 32'h8000;
`endif
                m_acc[sel] = r; m_z = (r == 0);
            end
            3: begin
                s = sx(a) - sx(d);
                r = (a - d) & 32'hFFFF;
                m_c = (a < d);
                m_v = (s > 32767) || (s < -32768);
`ifdef ACC_BANK_SATURATE_EN
                if (m_v) r = (s > 0) ? 32'h7FFF : 32'h8000;
`endif
                m_acc[sel] = r; m_z = (r == 0);
            end
            4: begin m_acc[sel] = 0; m_z = 1; m_c = 0; m_v = 0; end
            5: begin
                if (m_stack.size() == 8) m_err = 1;
                else m_stack.push_back(a);
            end
            6: begin
                if (m_stack.size() == 0) m_err = 1;
                else begin
                    r = m_stack.pop_back();
                    m_acc[sel] = r; m_z = (r == 0); m_c = 0; m_v = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic vec_t mk(input bit v, input bit [2:0] op, input bit [1:0] sel, input bit [15:0] d,
                                input bit [15:0] acc, input bit z, input bit c, input bit ov,
                                input bit full, input bit empty, input bit err);
        vec_t t;
        t.v = v; t.op = op; t.sel = sel; t.d = d; t.acc = acc;
        t.z = z; t.c = c; t.ov = ov; t.full = full; t.empty = empty; t.err = err;
        return t;
    endfunction

    task automatic step(input bit r, input bit v, input bit [2:0] op, input bit [1:0] sel, input bit [15:0] d);
        @(negedge clk);
        rst = r; bus.op_valid = v; bus.op = op; bus.sel = sel; bus.data_in = d;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_op(v, int'(op), int'(sel), d);
    endtask

    task automatic peek(input bit [1:0] s, output logic [15:0] val);
        bus.op_valid = 1'b0;
        bus.sel = s;
        #1;
        val = bus.acc_out;
    endtask

    task automatic check_model(input string tag);
        check({tag, " acc"},   bus.acc_out, m_acc[bus.sel]);
        check({tag, " z"},     bus.flag_z, m_z);
        check({tag, " c"},     bus.flag_c, m_c);
        check({tag, " v"},     bus.flag_v, m_v);
        check({tag, " full"},  bus.stack_full, m_stack.size() == 8);
        check({tag, " empty"}, bus.stack_empty, m_stack.size() == 0);
        check({tag, " err"},   bus.err, m_err);
    endtask

    task automatic check_status(input string tag, input bit full, input bit empty, input bit err);
        check({tag, " full"},  bus.stack_full, full);
        check({tag, " empty"}, bus.stack_empty, empty);
        check({tag, " err"},   bus.err, err);
    endtask

    initial begin
        logic [15:0] pv;
        bit [15:0] d;

        rst = 1'b1; bus.op_valid = 1'b0; bus.op = 3'd0; bus.sel = 2'd0; bus.data_in = 16'd0;
        step(1, 0, 3'd0, 2'd0, 16'd0);
        step(1, 0, 3'd0, 2'd0, 16'd0);
        for (int s = 0; s < 4; s++) begin
            peek(2'(s), pv);
            check($sformatf("reset acc%0d", s), pv, 16'h0000);
        end
        check("reset z", bus.flag_z, 1'b0);
        check("reset c", bus.flag_c, 1'b0);
        check("reset v", bus.flag_v, 1'b0);
        check_status("reset", 0, 1, 0);

        step(0, 1, 3'd1, 2'd2, 16'h1234);
        check("load2 acc", bus.acc_out, 16'h1234);
        check("load2 z", bus.flag_z, 1'b0);
        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin
                peek(2'(s), pv);
                check($sformatf("load2 other acc%0d", s), pv, 16'h0000);
            end
        end

        tbl.push_back(mk(1, 3'd1, 2'd1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd2, 2'd1, 16'h0001, 16'h0000, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd1, 2'd0, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 1, 0));
`ifdef ACC_BANK_SATURATE_EN
        tbl.push_back(mk(1, 3'd2, 2'd0, 16'h0001, 16'h7FFF, 0, 0, 1, 0, 1, 0));
`else
        tbl.push_back(mk(1, 3'd2, 2'd0, 16'h0001, 16'h8000, 0, 0, 1, 0, 1, 0));
`endif
        tbl.push_back(mk(1, 3'd1, 2'd3, 16'h0003, 16'h0003, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd3, 2'd3, 16'h0005, 16'hFFFE, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'd3, 2'd3, 16'h0005, 16'hFFFE, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd4, 2'd3, 16'hAAAA, 16'h0000, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd7, 2'd2, 16'hABCD, 16'h1234, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd6, 2'd2, 16'h0000, 16'h1234, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 3'd5, 2'd2, 16'h0000, 16'h1234, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'd6, 2'd0, 16'h0000, 16'h1234, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd3, 2'd1, 16'h0001, 16'hFFFF, 0, 1, 0, 0, 1, 0));
`ifdef ACC_BANK_SATURATE_EN
        tbl.push_back(mk(1, 3'd2, 2'd1, 16'h8000, 16'h8000, 0, 1, 1, 0, 1, 0));
`else
        tbl.push_back(mk(1, 3'd2, 2'd1, 16'h8000, 16'h7FFF, 0, 1, 1, 0, 1, 0));
`endif
        tbl.push_back(mk(1, 3'd1, 2'd0, 16'h8000, 16'h8000, 0, 0, 0, 0, 1, 0));
`ifdef ACC_BANK_SATURATE_EN
        tbl.push_back(mk(1, 3'd3, 2'd0, 16'h0001, 16'h8000, 0, 0, 1, 0, 1, 0));
`else
        tbl.push_back(mk(1, 3'd3, 2'd0, 16'h0001, 16'h7FFF, 0, 0, 1, 0, 1, 0));
`endif

        foreach (tbl[k]) begin
            step(0, tbl[k].v, tbl[k].op, tbl[k].sel, tbl[k].d);
            check($sformatf("vec%0d acc", k), bus.acc_out, tbl[k].acc);
            check($sformatf("vec%0d z", k), bus.flag_z, tbl[k].z);
            check($sformatf("vec%0d c", k), bus.flag_c, tbl[k].c);
            check($sformatf("vec%0d v", k), bus.flag_v, tbl[k].ov);
            check_status($sformatf("vec%0d", k), tbl[k].full, tbl[k].empty, tbl[k].err);
        end

        // Stack fill / overflow / drain / underflow
        step(1, 0, 3'd0, 2'd0, 16'd0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 3'd1, 2'd0, 16'(i));
            step(0, 1, 3'd5, 2'd0, 16'd0);
            check_status($sformatf("push%0d", i), i == 8, 0, 0);
        end
        step(0, 1, 3'd5, 2'd0, 16'd0);
        check_status("push9", 1, 0, 1);
        step(0, 1, 3'd0, 2'd0, 16'd0);
        check_status("push9 after", 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 3'd6, 2'd1, 16'd0);
            check($sformatf("pop%0d acc", i), bus.acc_out, 16'(9 - i));
            check_status($sformatf("pop%0d", i), 0, i == 8, 0);
        end
        step(0, 1, 3'd6, 2'd1, 16'd0);
        check("pop9 acc", bus.acc_out, 16'h0001);
        check_status("pop9", 0, 1, 1);
        step(0, 1, 3'd6, 2'd1, 16'd0);
        check_status("pop10", 0, 1, 1);
        step(0, 1, 3'd0, 2'd1, 16'd0);
        check_status("pop10 after", 0, 1, 0);

        // Reset wins over an ADD in the same cycle
        step(1, 0, 3'd0, 2'd0, 16'd0);
        step(0, 1, 3'd1, 2'd0, 16'h0010);
        for (int i = 0; i < 3; i++) step(0, 1, 3'd5, 2'd0, 16'd0);
        step(0, 1, 3'd1, 2'd1, 16'hFFFF);
        step(0, 1, 3'd2, 2'd1, 16'h0001);
        check("pre-rst z", bus.flag_z, 1'b1);
        step(1, 1, 3'd2, 2'd0, 16'h0005);
        check("rstop acc0", bus.acc_out, 16'h0000);
        check("rstop z", bus.flag_z, 1'b0);
        check("rstop c", bus.flag_c, 1'b0);
        check("rstop v", bus.flag_v, 1'b0);
        check_status("rstop", 0, 1, 0);
        peek(2'd1, pv);
        check("rstop acc1", pv, 16'h0000);

        // Random traffic against the reference model
        step(1, 0, 3'd0, 2'd0, 16'd0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom % 6)
                0: d = 16'h0000;
                1: d = 16'h0001;
                2: d = 16'hFFFF;
                3: d = 16'h7FFF;
                4: d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            step(($urandom % 128) == 0, ($urandom % 8) != 0, 3'($urandom), 2'($urandom), d);
            check_model($sformatf("rnd%0d", i));
            if ((i % 8) == 7) begin
                for (int s = 0; s < 4; s++) begin
                    peek(2'(s), pv);
                    check($sformatf("rnd%0d peek%0d", i, s), pv, m_acc[s]);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
